// File: rtl/ysyx_23060136_ifu_fetch_queue_if.sv
// Fetch-queue bus: ICACHE-side fetch packets in, single instructions out toward the IFU/IDU register.
// The master modport is the surrounding fetch logic; the queue itself uses slave.
interface ysyx_23060136_ifu_fetch_queue_if #(
  parameter int BITS_W  = 32,
  parameter int INST_W  = 32,
  parameter int FETCH_N = 2,
  parameter int DEPTH   = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                       in_valid;
  logic                       in_ready;
  logic [BITS_W-1:0]          in_pc;
  logic [FETCH_N*INST_W-1:0]  in_inst;
  logic [FETCH_N-1:0]         in_mask;
  logic [FETCH_N-1:0]         in_pre_take;
  logic                       out_valid;
  logic [INST_W-1:0]          out_inst;
  logic [BITS_W-1:0]          out_pc;
  logic                       out_pre_take;
  logic [CNT_W-1:0]           out_count;

  modport master (
    output in_valid, in_pc, in_inst, in_mask, in_pre_take,
    input  in_ready, out_valid, out_inst, out_pc, out_pre_take, out_count
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_mask, in_pre_take,
    output in_ready, out_valid, out_inst, out_pc, out_pre_take, out_count
  );
endinterface

// File: rtl/ysyx_23060136_ifu_fetch_queue.sv
// Instruction fetch queue: compacts masked multi-slot fetch packets into a circular buffer
// and issues one instruction per cycle; a branch flush empties it in a single cycle.
module ysyx_23060136_ifu_fetch_queue #(
  parameter int BITS_W  = 32,
  parameter int INST_W  = 32,
  parameter int FETCH_N = 2,
  parameter int DEPTH   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic BRANCH_flushIF,
  input  logic FORWARD_stallIF,
  ysyx_23060136_ifu_fetch_queue_if.slave io
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] READY_MAX = PTR_W'(DEPTH - FETCH_N);

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [BITS_W-1:0] pc_mem   [DEPTH];
  logic              pt_mem   [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  count;
  logic [PTR_W-1:0]  push_cnt;
  logic [IDX_W-1:0]  head_idx;
  logic [IDX_W-1:0]  wr_idx [FETCH_N];
  logic              push;
  logic              pop;

  // The extra pointer MSB makes tail-head range 0..DEPTH without ambiguity.
  assign count    = tail - head;
  assign head_idx = head[IDX_W-1:0];

  assign io.in_ready     = (count <= READY_MAX);
  assign io.out_valid    = (count != '0);
  assign io.out_count    = count;
  assign io.out_inst     = inst_mem[head_idx];
  assign io.out_pc       = pc_mem[head_idx];
  assign io.out_pre_take = pt_mem[head_idx];

  assign push = io.in_valid && io.in_ready && !BRANCH_flushIF;
  assign pop  = io.out_valid && !FORWARD_stallIF && !BRANCH_flushIF;

  // Each set slot lands at tail plus the number of set slots below it, closing gaps.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < FETCH_N; i++) begin
      wr_idx[i] = IDX_W'(tail + push_cnt);
      push_cnt  = push_cnt + PTR_W'(io.in_mask[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        inst_mem[e] <= '0;
        pc_mem[e]   <= '0;
        pt_mem[e]   <= 1'b0;
      end
    end else if (BRANCH_flushIF) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) begin
        for (int i = 0; i < FETCH_N; i++) begin
          if (io.in_mask[i]) begin
            inst_mem[wr_idx[i]] <= io.in_inst[i*INST_W +: INST_W];
            pc_mem[wr_idx[i]]   <= io.in_pc + BITS_W'(4 * i);
            pt_mem[wr_idx[i]]   <= io.in_pre_take[i];
          end
        end
        tail <= tail + push_cnt;
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_ysyx_23060136_ifu_fetch_queue.sv
// Self-checking bench for the fetch queue: directed vector table, a wrap-around stream,
// randomized traffic against a queue-based reference model, and a mid-stream async reset.
module tb_ysyx_23060136_ifu_fetch_queue;
  localparam int BITS_W  = 32;
  localparam int INST_W  = 32;
  localparam int FETCH_N = 2;
  localparam int DEPTH   = 8;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060136_ifu_fetch_queue_if #(
    .BITS_W(BITS_W), .INST_W(INST_W), .FETCH_N(FETCH_N), .DEPTH(DEPTH)
  ) fq_if ();

  ysyx_23060136_ifu_fetch_queue #(
    .BITS_W(BITS_W), .INST_W(INST_W), .FETCH_N(FETCH_N), .DEPTH(DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .BRANCH_flushIF  (flush),
    .FORWARD_stallIF (stall),
    .io              (fq_if)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pt;
  } ent_t;

  ent_t model_q[$];

  typedef struct {
    logic        f;
    logic        s;
    logic        v;
    logic [1:0]  m;
    logic [1:0]  pt;
    logic [31:0] pc;
    logic        ev;
    int          ec;
    logic        er;
    logic [31:0] epc;
    logic        ept;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a plain FIFO of entries; acceptance judged on occupancy before the edge.
  task automatic modelUpdate(input logic f, input logic s, input logic v,
                             input logic [1:0] m, input logic [1:0] pt, input logic [31:0] pc);
    int  sz;
    bit  ready;
    ent_t e;
    sz    = model_q.size();
    ready = (DEPTH - sz) >= FETCH_N;
    if (f) begin
      model_q.delete();
    end else begin
      if (sz != 0 && !s) void'(model_q.pop_front());
      if (v && ready) begin
        for (int i = 0; i < FETCH_N; i++) begin
          if (m[i]) begin
            e.pc   = pc + 32'(4 * i);
            e.inst = inst_of(e.pc);
            e.pt   = pt[i];
            model_q.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    int sz;
    sz = model_q.size();
    check("out_valid", 32'(fq_if.out_valid), 32'(sz != 0));
    check("out_count", 32'(fq_if.out_count), 32'(sz));
    check("in_ready", 32'(fq_if.in_ready), 32'((DEPTH - sz) >= FETCH_N));
    if (sz != 0) begin
      check("out_pc", fq_if.out_pc, model_q[0].pc);
      check("out_inst", fq_if.out_inst, model_q[0].inst);
      check("out_pre_take", 32'(fq_if.out_pre_take), 32'(model_q[0].pt));
    end
  endtask

  task automatic checkResetValues();
    check("rst_out_valid", 32'(fq_if.out_valid), 32'd0);
    check("rst_out_count", 32'(fq_if.out_count), 32'd0);
    check("rst_out_inst", fq_if.out_inst, 32'd0);
    check("rst_out_pc", fq_if.out_pc, 32'd0);
    check("rst_out_pre_take", 32'(fq_if.out_pre_take), 32'd0);
    check("rst_in_ready", 32'(fq_if.in_ready), 32'd1);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare after it.
  task automatic applyStimulus(input logic f, input logic s, input logic v,
                               input logic [1:0] m, input logic [1:0] pt, input logic [31:0] pc);
    flush                = f;
    stall                = s;
    fq_if.in_valid       = v;
    fq_if.in_mask        = m;
    fq_if.in_pre_take    = pt;
    fq_if.in_pc          = pc;
    for (int i = 0; i < FETCH_N; i++) begin
      fq_if.in_inst[i*INST_W +: INST_W] = inst_of(pc + 32'(4 * i));
    end
    @(posedge clk);
    modelUpdate(f, s, v, m, pt, pc);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [31:0] pc;
    logic        rdy;

    rst                = 1'b1;
    flush              = 1'b0;
    stall              = 1'b0;
    fq_if.in_valid     = 1'b0;
    fq_if.in_mask      = '0;
    fq_if.in_pre_take  = '0;
    fq_if.in_pc        = '0;
    fq_if.in_inst      = '0;
    #2;
    checkResetValues();
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    //                 f  s  v  m      pt     pc             ev ec er epc            ept
    vecs.push_back('{1'b0,1'b0,1'b1,2'b11,2'b01,32'h8000_0000,1'b1,2,1'b1,32'h8000_0000,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,2'b00,2'b00,32'h0000_0000,1'b1,1,1'b1,32'h8000_0004,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,2'b00,2'b00,32'h0000_0000,1'b0,0,1'b1,32'h0000_0000,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b1,2'b10,2'b10,32'h8000_0010,1'b1,1,1'b1,32'h8000_0014,1'b1});
    vecs.push_back('{1'b0,1'b1,1'b1,2'b11,2'b00,32'h8000_0020,1'b1,3,1'b1,32'h8000_0014,1'b1});
    vecs.push_back('{1'b0,1'b1,1'b1,2'b11,2'b00,32'h8000_0030,1'b1,5,1'b1,32'h8000_0014,1'b1});
    vecs.push_back('{1'b0,1'b1,1'b1,2'b11,2'b00,32'h8000_0040,1'b1,7,1'b0,32'h8000_0014,1'b1});
    vecs.push_back('{1'b0,1'b1,1'b1,2'b11,2'b00,32'h8000_0050,1'b1,7,1'b0,32'h8000_0014,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,2'b00,2'b00,32'h0000_0000,1'b1,6,1'b1,32'h8000_0020,1'b0});
    vecs.push_back('{1'b1,1'b0,1'b1,2'b11,2'b11,32'h8000_0060,1'b0,0,1'b1,32'h0000_0000,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b1,2'b11,2'b10,32'h9000_0000,1'b1,2,1'b1,32'h9000_0000,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b1,2'b11,2'b00,32'h9000_0008,1'b1,4,1'b1,32'h9000_0000,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b1,2'b11,2'b00,32'h9000_0010,1'b1,6,1'b1,32'h9000_0000,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b1,2'b11,2'b00,32'h9000_0018,1'b1,8,1'b0,32'h9000_0000,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b1,2'b11,2'b00,32'hA000_0000,1'b1,7,1'b0,32'h9000_0004,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b1,2'b11,2'b00,32'hA000_0000,1'b1,6,1'b1,32'h9000_0008,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,2'b00,2'b00,32'h0000_0000,1'b1,5,1'b1,32'h9000_000C,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,2'b00,2'b00,32'h0000_0000,1'b1,4,1'b1,32'h9000_0010,1'b0});
    vecs.push_back('{1'b1,1'b0,1'b1,2'b11,2'b11,32'hA000_0000,1'b0,0,1'b1,32'h0000_0000,1'b0});

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].f, vecs[k].s, vecs[k].v, vecs[k].m, vecs[k].pt, vecs[k].pc);
      check($sformatf("tbl%0d_valid", k), 32'(fq_if.out_valid), 32'(vecs[k].ev));
      check($sformatf("tbl%0d_count", k), 32'(fq_if.out_count), 32'(vecs[k].ec));
      check($sformatf("tbl%0d_ready", k), 32'(fq_if.in_ready), 32'(vecs[k].er));
      if (vecs[k].ev) begin
        check($sformatf("tbl%0d_pc", k), fq_if.out_pc, vecs[k].epc);
        check($sformatf("tbl%0d_inst", k), fq_if.out_inst, inst_of(vecs[k].epc));
        check($sformatf("tbl%0d_pt", k), 32'(fq_if.out_pre_take), 32'(vecs[k].ept));
      end
    end

    // Full packets against a 1-wide consumer: pointers wrap many times, producer holds when blocked.
    pc = 32'h4000_0000;
    for (int c = 0; c < 60; c++) begin
      rdy = fq_if.in_ready;
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 2'(c), pc);
      if (rdy) pc = pc + 32'd8;
    end

    pc = 32'h2000_0000;
    for (int c = 0; c < 600; c++) begin
      logic f, s, v;
      logic [1:0] m, pt;
      f   = ($urandom_range(0, 31) == 0);
      s   = ($urandom_range(0, 3) == 0);
      v   = ($urandom_range(0, 3) != 0);
      m   = 2'($urandom);
      pt  = 2'($urandom);
      rdy = fq_if.in_ready;
      applyStimulus(f, s, v, m, pt, pc);
      if (v && rdy && !f) pc = pc + 32'd16;
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 32'h7000_0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 32'h7000_0008);
    #3;
    rst = 1'b1;
    #1;
    model_q.delete();
    checkResetValues();
    @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 32'h1234_0000);
    check("post_rst_pc", fq_if.out_pc, 32'h1234_0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0);
    check("post_rst_count", 32'(fq_if.out_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
